// File: rtl/hamming_rx_serie.sv
// Serial Hamming(12,8) even-parity receiver: deserialises p1-first codewords, computes the
// syndrome, optionally corrects single-bit errors and presents the byte on a valid/ready port.
module hamming_rx_serie #(
  parameter logic CORREGIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_valido,
  input  logic       bit_serie,
  input  logic       inicio,
  output logic [7:0] datos_out,
  output logic       datos_valido,
  input  logic       datos_listo,
  output logic [3:0] sindrome,
  output logic       error_corregido,
  output logic       error_invalido,
  output logic       desborde
);

  localparam logic [1:0] ESPERA     = 2'd0;
  localparam logic [1:0] RECIBE     = 2'd1;
  localparam logic [1:0] DECODIFICA = 2'd2;

  // Each syndrome bit is the even parity of the positions whose index has that bit set.
  function automatic logic [3:0] calc_sindrome(input logic [11:0] c);
    calc_sindrome = {^{c[4], c[3], c[2], c[1], c[0]},
                     ^{c[8], c[7], c[6], c[5], c[0]},
                     ^{c[10], c[9], c[6], c[5], c[2], c[1]},
                     ^{c[11], c[9], c[7], c[5], c[3], c[1]}};
  endfunction

  // Position p lives at c[12-p]; out-of-range syndromes select no bit.
  function automatic logic [11:0] flip_mask(input logic [3:0] s);
    case (s)
      4'd1:    flip_mask = 12'h800;
      4'd2:    flip_mask = 12'h400;
      4'd3:    flip_mask = 12'h200;
      4'd4:    flip_mask = 12'h100;
      4'd5:    flip_mask = 12'h080;
      4'd6:    flip_mask = 12'h040;
      4'd7:    flip_mask = 12'h020;
      4'd8:    flip_mask = 12'h010;
      4'd9:    flip_mask = 12'h008;
      4'd10:   flip_mask = 12'h004;
      4'd11:   flip_mask = 12'h002;
      4'd12:   flip_mask = 12'h001;
      default: flip_mask = 12'h000;
    endcase
  endfunction

  logic [1:0]  state_q, state_d;
  logic [11:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load_s;
  logic        start_s;

  logic [3:0]  sind_s;
  logic        err_corr_s;
  logic        err_inv_s;
  logic [11:0] word_fix_s;
  logic [7:0]  datos_s;

  logic [7:0]  datos_q;
  logic [3:0]  sind_q;
  logic        valido_q;
  logic        err_corr_q;
  logic        err_inv_q;
  logic        desborde_q;

  assign start_s = bit_valido & inicio;

  // Decoder datapath, evaluated from the shift register during DECODIFICA.
  always_comb begin
    sind_s     = calc_sindrome(shift_q);
    err_corr_s = (sind_s != 4'd0) && (sind_s <= 4'd12);
    err_inv_s  = (sind_s >= 4'd13);
    if (CORREGIR) begin
      word_fix_s = shift_q ^ flip_mask(sind_s);
    end else begin
      word_fix_s = shift_q;
    end
    datos_s = {word_fix_s[9], word_fix_s[7], word_fix_s[6], word_fix_s[5],
               word_fix_s[3], word_fix_s[2], word_fix_s[1], word_fix_s[0]};
  end

  // Receive FSM next-state logic; inicio always restarts a frame, even mid-word.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    load_s  = 1'b0;
    case (state_q)
      ESPERA: begin
        if (start_s) begin
          shift_d = {11'd0, bit_serie};
          cnt_d   = 4'd1;
          state_d = RECIBE;
        end else begin
          state_d = ESPERA;
        end
      end
      RECIBE: begin
        if (start_s) begin
          shift_d = {11'd0, bit_serie};
          cnt_d   = 4'd1;
          state_d = RECIBE;
        end else if (bit_valido) begin
          shift_d = {shift_q[10:0], bit_serie};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd11) begin
            state_d = DECODIFICA;
          end else begin
            state_d = RECIBE;
          end
        end else begin
          state_d = RECIBE;
        end
      end
      DECODIFICA: begin
        load_s = 1'b1;
        if (start_s) begin
          shift_d = {11'd0, bit_serie};
          cnt_d   = 4'd1;
          state_d = RECIBE;
        end else begin
          cnt_d   = 4'd0;
          state_d = ESPERA;
        end
      end
      default: begin
        shift_d = 12'd0;
        cnt_d   = 4'd0;
        state_d = ESPERA;
      end
    endcase
  end

  // Receive FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ESPERA;
      shift_q <= 12'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // One-entry output buffer; a load that finds it occupied and not draining is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      datos_q    <= 8'd0;
      sind_q     <= 4'd0;
      valido_q   <= 1'b0;
      err_corr_q <= 1'b0;
      err_inv_q  <= 1'b0;
      desborde_q <= 1'b0;
    end else begin
      desborde_q <= load_s & valido_q & ~datos_listo;
      if (load_s && (!valido_q || datos_listo)) begin
        datos_q    <= datos_s;
        sind_q     <= sind_s;
        err_corr_q <= err_corr_s;
        err_inv_q  <= err_inv_s;
        valido_q   <= 1'b1;
      end else if (valido_q && datos_listo) begin
        valido_q   <= 1'b0;
      end else begin
        valido_q   <= valido_q;
      end
    end
  end

  assign datos_out       = datos_q;
  assign datos_valido    = valido_q;
  assign sindrome        = sind_q;
  assign error_corregido = err_corr_q;
  assign error_invalido  = err_inv_q;
  assign desborde        = desborde_q;

endmodule

// File: tb/tb_hamming_rx_serie.sv
// Self-checking bench for hamming_rx_serie: directed cases plus randomized words checked
// against a position-XOR Hamming model; a CORREGIR=0 instance runs in parallel.
module tb_hamming_rx_serie;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_valido = 1'b0;
  logic       bit_serie = 1'b0;
  logic       inicio = 1'b0;
  logic       datos_listo = 1'b0;
  logic [7:0] datos_out, datos_out_nc;
  logic       datos_valido, datos_valido_nc;
  logic [3:0] sindrome, sindrome_nc;
  logic       error_corregido, error_corregido_nc;
  logic       error_invalido, error_invalido_nc;
  logic       desborde, desborde_nc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_rx_serie #(.CORREGIR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bit_valido(bit_valido), .bit_serie(bit_serie),
    .inicio(inicio), .datos_out(datos_out), .datos_valido(datos_valido),
    .datos_listo(datos_listo), .sindrome(sindrome), .error_corregido(error_corregido),
    .error_invalido(error_invalido), .desborde(desborde)
  );

  hamming_rx_serie #(.CORREGIR(1'b0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .bit_valido(bit_valido), .bit_serie(bit_serie),
    .inicio(inicio), .datos_out(datos_out_nc), .datos_valido(datos_valido_nc),
    .datos_listo(datos_listo), .sindrome(sindrome_nc), .error_corregido(error_corregido_nc),
    .error_invalido(error_invalido_nc), .desborde(desborde_nc)
  );

  // Observed bundle: {valid, data, syndrome, corrected, invalid}
  logic [14:0] obs, obs_nc;
  assign obs    = {datos_valido, datos_out, sindrome, error_corregido, error_invalido};
  assign obs_nc = {datos_valido_nc, datos_out_nc, sindrome_nc, error_corregido_nc, error_invalido_nc};

  // Codeword position holding data bit d(i+1), i = 0..7.
  function automatic int data_pos(input int i);
    case (i)
      0: data_pos = 3;   1: data_pos = 5;   2: data_pos = 6;   3: data_pos = 7;
      4: data_pos = 9;   5: data_pos = 10;  6: data_pos = 11;  default: data_pos = 12;
    endcase
  endfunction

  function automatic logic [11:0] encode(input logic [7:0] d);
    logic [11:0] c = 12'd0;
    int x = 0;
    for (int i = 0; i < 8; i++) begin
      if (d[7-i]) begin
        c[12-data_pos(i)] = 1'b1;
        x = x ^ data_pos(i);
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (((x >> k) & 1) == 1) c[12-(1 << k)] = 1'b1;
    end
    return c;
  endfunction

  // Syndrome = XOR of the positions of all set bits.
  function automatic logic [14:0] model(input logic [11:0] cw, input bit corr);
    int s = 0;
    logic [11:0] f;
    logic [7:0] d;
    logic ec, ei;
    for (int p = 1; p <= 12; p++) if (cw[12-p]) s = s ^ p;
    ec = (s >= 1) && (s <= 12);
    ei = (s >= 13);
    f = cw;
    if (corr && ec) f[12-s] = ~f[12-s];
    for (int i = 0; i < 8; i++) d[7-i] = f[12-data_pos(i)];
    return {1'b1, d, s[3:0], ec, ei};
  endfunction

  task automatic send_bits(input logic [11:0] cw, input int gap);
    for (int i = 11; i >= 0; i--) begin
      @(negedge clk);
      bit_valido = 1'b1;
      bit_serie  = cw[i];
      inicio     = (i == 11);
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          bit_valido = 1'b0;
          inicio     = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bit_valido = 1'b0;
      inicio     = 1'b0;
    end
  endtask

  task automatic accept();
    @(negedge clk);
    datos_listo = 1'b1;
    @(negedge clk);
    datos_listo = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({obs, desborde} !== 16'd0) begin
      errors++;
      $display("FAIL reset_held: got %h want 0000", {obs, desborde});
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    checks++;
    if ({obs, desborde} !== 16'd0) begin
      errors++;
      $display("FAIL reset_released: got %h want 0000", {obs, desborde});
    end
  endtask

  task automatic test_directed();
    logic [11:0] cws [4]    = '{12'hE45, 12'hEC5, 12'h645, 12'h644};
    logic [14:0] exp_c [4]  = '{{1'b1, 8'hA5, 4'd0, 2'b00}, {1'b1, 8'hA5, 4'd5, 2'b10},
                                {1'b1, 8'hA5, 4'd1, 2'b10}, {1'b1, 8'hA4, 4'd13, 2'b01}};
    logic [14:0] exp_nc [4] = '{{1'b1, 8'hA5, 4'd0, 2'b00}, {1'b1, 8'hE5, 4'd5, 2'b10},
                                {1'b1, 8'hA5, 4'd1, 2'b10}, {1'b1, 8'hA4, 4'd13, 2'b01}};
    for (int t = 0; t < 4; t++) begin
      send_bits(cws[t], 0);
      idle(1);
      checks++;
      if (datos_valido !== 1'b0) begin
        errors++;
        $display("FAIL latency_early[%0d]: valid=%b want 0 one cycle after last bit", t, datos_valido);
      end
      @(negedge clk);
      checks++;
      if (obs !== exp_c[t]) begin
        errors++;
        $display("FAIL directed[%0d] cw=%h: got %h want %h", t, cws[t], obs, exp_c[t]);
      end
      checks++;
      if (obs_nc !== exp_nc[t]) begin
        errors++;
        $display("FAIL directed_nc[%0d] cw=%h: got %h want %h", t, cws[t], obs_nc, exp_nc[t]);
      end
      accept();
      checks++;
      if (datos_valido !== 1'b0) begin
        errors++;
        $display("FAIL accept[%0d]: valid=%b want 0", t, datos_valido);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      logic [7:0]  d = 8'($urandom);
      logic [11:0] cw = encode(d);
      int nerr = int'($urandom_range(0, 2));
      int p1 = int'($urandom_range(1, 12));
      int p2 = 1 + ((p1 + int'($urandom_range(0, 10))) % 12);
      int gap = int'($urandom_range(0, 2));
      logic [14:0] e, enc;
      if (nerr >= 1) cw[12-p1] = ~cw[12-p1];
      if (nerr == 2) cw[12-p2] = ~cw[12-p2];
      e   = model(cw, 1'b1);
      enc = model(cw, 1'b0);
      send_bits(cw, gap);
      idle(2);
      checks++;
      if ({obs, desborde} !== {e, 1'b0}) begin
        errors++;
        $display("FAIL random[%0d] cw=%h: got %h want %h", t, cw, {obs, desborde}, {e, 1'b0});
      end
      checks++;
      if (obs_nc !== enc) begin
        errors++;
        $display("FAIL random_nc[%0d] cw=%h: got %h want %h", t, cw, obs_nc, enc);
      end
      accept();
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] w1 = encode(8'h3C);
    logic [11:0] w2 = encode(8'hC7);
    // Output occupied and not accepted: second word dropped
    send_bits(w1, 0);
    send_bits(w2, 0);
    idle(1);
    checks++;
    if ({obs, desborde} !== {1'b1, 8'h3C, 4'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL b2b_hold: got %h want %h", {obs, desborde}, {1'b1, 8'h3C, 4'd0, 2'b00, 1'b0});
    end
    @(negedge clk);
    checks++;
    if ({obs, desborde} !== {1'b1, 8'h3C, 4'd0, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL b2b_drop: got %h want %h", {obs, desborde}, {1'b1, 8'h3C, 4'd0, 2'b00, 1'b1});
    end
    @(negedge clk);
    checks++;
    if ({obs, desborde} !== {1'b1, 8'h3C, 4'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL b2b_pulse_end: got %h want %h", {obs, desborde}, {1'b1, 8'h3C, 4'd0, 2'b00, 1'b0});
    end
    accept();
    checks++;
    if (datos_valido !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: valid=%b want 0", datos_valido);
    end
    // Accept in the load cycle: second word replaces first with no gap in valid
    send_bits(w1, 0);
    send_bits(w2, 0);
    idle(1);
    datos_listo = 1'b1;
    @(negedge clk);
    datos_listo = 1'b0;
    checks++;
    if ({obs, desborde} !== {1'b1, 8'hC7, 4'd0, 2'b00, 1'b0}) begin
      errors++;
      $display("FAIL b2b_swap: got %h want %h", {obs, desborde}, {1'b1, 8'hC7, 4'd0, 2'b00, 1'b0});
    end
    accept();
  endtask

  task automatic test_abort();
    logic [11:0] junk = 12'h9B3;
    // Strobes without inicio while idle must be ignored
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      bit_valido = 1'b1;
      bit_serie  = junk[i % 12];
      inicio     = 1'b0;
    end
    idle(3);
    checks++;
    if (datos_valido !== 1'b0) begin
      errors++;
      $display("FAIL ignore_no_inicio: valid=%b want 0", datos_valido);
    end
    for (int i = 11; i >= 5; i--) begin
      @(negedge clk);
      bit_valido = 1'b1;
      bit_serie  = junk[i];
      inicio     = (i == 11);
    end
    send_bits(12'hE45, 0);
    idle(2);
    checks++;
    if (obs !== {1'b1, 8'hA5, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL abort_restart: got %h want %h", obs, {1'b1, 8'hA5, 4'd0, 2'b00});
    end
    accept();
    idle(16);
    checks++;
    if (datos_valido !== 1'b0) begin
      errors++;
      $display("FAIL abort_single: valid=%b want 0", datos_valido);
    end
  endtask

  task automatic test_reset_mid();
    // Reset with a word pending in the output register
    send_bits(12'hE45, 0);
    idle(2);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({obs, desborde} !== 16'd0) begin
      errors++;
      $display("FAIL reset_handshake: got %h want 0000", {obs, desborde});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 11; i >= 7; i--) begin
      @(negedge clk);
      bit_valido = 1'b1;
      bit_serie  = 1'b1;
      inicio     = (i == 11);
    end
    @(negedge clk);
    bit_valido = 1'b0;
    inicio     = 1'b0;
    rst_n      = 1'b0;
    #1;
    checks++;
    if ({obs, desborde} !== 16'd0) begin
      errors++;
      $display("FAIL reset_frame: got %h want 0000", {obs, desborde});
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_bits(12'hE45, 1);
    idle(2);
    checks++;
    if (obs !== {1'b1, 8'hA5, 4'd0, 2'b00}) begin
      errors++;
      $display("FAIL reset_recover: got %h want %h", obs, {1'b1, 8'hA5, 4'd0, 2'b00});
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
